// File: rtl/aes_pkg.sv
// Shared AES definitions for the pipelined encryption core.
//   - ctl_state_t : key-expansion controller states
//   - nr_of / nk_blk_of : round count and key size in 128-bit blocks
//   - sbox / sub_word / rcon / xtime : byte-level primitives
//   - aes_round : one encryption round (SubBytes, ShiftRows, optional
//     MixColumns, AddRoundKey) on a 128-bit state, byte 0 in the MSBs
package aes_pkg;

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY, S_DRAIN} ctl_state_t;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic int nr_of(input int key_length);
    return (key_length == 256) ? 14 : 10;
  endfunction

  function automatic int nk_blk_of(input int key_length);
    return (key_length == 256) ? 2 : 1;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] rk,
                                             input logic         last);
    logic [127:0] sb, sr, mc;
    logic [7:0]   a0, a1, a2, a3;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    // Byte (row r, column c) lives at index 4c+r; row r rotates left by r.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
    mc = sr;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[127-32*c -: 8];
        a1 = sr[119-32*c -: 8];
        a2 = sr[111-32*c -: 8];
        a3 = sr[103-32*c -: 8];
        mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return mc ^ rk;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One round-key expansion step, purely combinational.
//   prev2   : round key idx-2 (used only for 256-bit keys)
//   prev1   : round key idx-1
//   idx     : index of the round key being produced
//   mode256 : 1 for 256-bit keys, 0 for 128-bit keys
//   next    : round key idx
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] prev2,
  input  logic [127:0] prev1,
  input  logic [3:0]   idx,
  input  logic         mode256,
  output logic [127:0] next
);

  logic [31:0]  w3, temp, n0, n1, n2, n3;
  logic [127:0] base;
  logic         rot;
  logic [3:0]   rc_idx;

  always_comb begin
    w3     = prev1[31:0];
    // 256-bit keys: even blocks take the RotWord/Rcon step, odd ones SubWord only.
    rot    = !mode256 || !idx[0];
    rc_idx = mode256 ? {1'b0, idx[3:1]} : idx;
    temp   = rot ? (sub_word({w3[23:0], w3[31:24]}) ^ {rcon(rc_idx), 24'h0})
                 : sub_word(w3);
    base   = mode256 ? prev2 : prev1;
    n0     = base[127:96] ^ temp;
    n1     = base[95:64]  ^ n0;
    n2     = base[63:32]  ^ n1;
    n3     = base[31:0]   ^ n2;
    next   = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_enc_pipe_param.sv
// Fully pipelined AES encryptor for 128/256-bit keys with on-chip key expansion.
//   clk, rst           : clock, synchronous active-high reset
//   key_load, key_in   : load a new cipher key (byte 0 in MSBs)
//   key_ready          : all round keys valid
//   in_valid/in_ready  : plaintext handshake, in_data + in_tag
//   out_valid          : one-cycle ciphertext strobe, out_data + out_tag
// Controller states:
//   state    | meaning
//   S_IDLE   | no key loaded, inputs blocked
//   S_EXPAND | writing one round key per cycle
//   S_READY  | keys valid, accepting blocks
//   S_DRAIN  | new key pending, waiting for in-flight blocks to leave
module aes_enc_pipe_param
  import aes_pkg::*;
#(
  parameter int KEY_LENGTH = 128,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_load,
  input  logic [KEY_LENGTH-1:0] key_in,
  output logic                  key_ready,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          in_data,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  output logic [127:0]          out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int   NR      = nr_of(KEY_LENGTH);
  localparam int   NK_BLK  = nk_blk_of(KEY_LENGTH);
  localparam int   CW      = $clog2(NR + 3);
  localparam logic MODE256 = (NK_BLK == 2);

  if ((KEY_LENGTH != 128) && (KEY_LENGTH != 256)) begin : g_bad_key_length
    $error("aes_enc_pipe_param: KEY_LENGTH must be 128 or 256");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $error("aes_enc_pipe_param: TAG_WIDTH must be at least 1");
  end

  ctl_state_t                state, state_nxt;
  logic [3:0]                rk_idx, idx1, idx2;
  logic [127:0]              rk [0:NR];
  logic [KEY_LENGTH-1:0]     key_pend, load_key;
  logic [CW-1:0]             inflight;
  logic                      do_load, do_step, pend_we, accept;
  logic [127:0]              step_out;
  logic [NR:0]               st_valid;
  logic [127:0]              st_data [0:NR];
  logic [TAG_WIDTH-1:0]      st_tag  [0:NR];

  assign in_ready = (state == S_READY) && !key_load;
  assign accept   = in_valid && in_ready;
  assign load_key = (state == S_DRAIN) ? key_pend : key_in;
  assign idx1     = (rk_idx == 4'd0) ? 4'd0 : rk_idx - 4'd1;
  assign idx2     = (rk_idx < 4'd2)  ? 4'd0 : rk_idx - 4'd2;

  aes_key_step u_key_step (
    .prev2   (rk[idx2]),
    .prev1   (rk[idx1]),
    .idx     (rk_idx),
    .mode256 (MODE256),
    .next    (step_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_step   = 1'b0;
    pend_we   = 1'b0;
    case (state)
      S_IDLE: if (key_load) begin
        do_load   = 1'b1;
        state_nxt = S_EXPAND;
      end
      S_EXPAND: begin
        do_step = 1'b1;
        if (rk_idx == 4'(NR)) state_nxt = S_READY;
      end
      S_READY: if (key_load) begin
        if (inflight == '0) begin
          do_load   = 1'b1;
          state_nxt = S_EXPAND;
        end else begin
          pend_we   = 1'b1;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (inflight == '0) begin
        do_load   = 1'b1;
        state_nxt = S_EXPAND;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk_idx    <= '0;
      key_pend  <= '0;
      key_ready <= 1'b0;
      inflight  <= '0;
      for (int k = 0; k <= NR; k++) rk[k] <= '0;
    end else begin
      key_ready <= (state_nxt == S_READY);
      if (pend_we) key_pend <= key_in;
      if (do_load) begin
        for (int b = 0; b < NK_BLK; b++) rk[b] <= load_key[KEY_LENGTH-1-128*b -: 128];
        rk_idx <= 4'(NK_BLK);
      end else if (do_step) begin
        rk[rk_idx] <= step_out;
        rk_idx     <= rk_idx + 4'd1;
      end
      case ({accept, out_valid})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_valid <= '0;
      for (int k = 0; k <= NR; k++) begin
        st_data[k] <= '0;
        st_tag[k]  <= '0;
      end
    end else begin
      st_valid   <= {st_valid[NR-1:0], accept};
      st_data[0] <= in_data ^ rk[0];
      st_tag[0]  <= in_tag;
      for (int k = 1; k <= NR; k++) begin
        st_data[k] <= aes_round(st_data[k-1], rk[k], k == NR);
        st_tag[k]  <= st_tag[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= st_valid[NR];
      if (st_valid[NR]) begin
        out_data <= st_data[NR];
        out_tag  <= st_tag[NR];
      end
    end
  end

endmodule

// File: tb/tb_aes_enc_pipe_param.sv
module tb_aes_enc_pipe_param;

  localparam logic [127:0] K_C1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K_C3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] RK10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  logic clk, rst;
  logic kl_a, kr_a, iv_a, ir_a, ov_a;
  logic [127:0] key_a, id_a, od_a;
  logic [4:0]   it_a, ot_a;
  logic kl_b, kr_b, iv_b, ir_b, ov_b;
  logic [255:0] key_b;
  logic [127:0] id_b, od_b;
  logic [3:0]   it_b, ot_b;

  int total = 0;
  int bad   = 0;

  logic [127:0] pt_t [5];
  logic [127:0] ct_t [5];
  logic [127:0] od_s [4];
  logic [4:0]   ot_s [4];

  aes_enc_pipe_param #(.KEY_LENGTH(128), .TAG_WIDTH(5)) d128 (
    .clk(clk), .rst(rst), .key_load(kl_a), .key_in(key_a), .key_ready(kr_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a), .in_tag(it_a),
    .out_valid(ov_a), .out_data(od_a), .out_tag(ot_a));

  aes_enc_pipe_param #(.KEY_LENGTH(256), .TAG_WIDTH(4)) d256 (
    .clk(clk), .rst(rst), .key_load(kl_b), .key_in(key_b), .key_ready(kr_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b), .in_tag(it_b),
    .out_valid(ov_b), .out_data(od_b), .out_tag(ot_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int ca, cb, la, lb, na, nb, got, first, last, n, rise, seen3, viol, kc, irc;
    logic [127:0] da, db;
    logic [4:0]   ta;
    logic [3:0]   tb;
    logic         sent;

    pt_t[0] = 128'h3243f6a8885a308d313198a2e0370734; ct_t[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    pt_t[1] = 128'h6bc1bee22e409f96e93d7e117393172a; ct_t[1] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    pt_t[2] = 128'hae2d8a571e03ac9c9eb76fac45af8e51; ct_t[2] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    pt_t[3] = 128'h30c81c46a35ce411e5fbc1191a0a52ef; ct_t[3] = 128'h43b1cd7f598ece23881b00e3ed030688;
    pt_t[4] = 128'hf69f2445df4f9b17ad2b417be66c3710; ct_t[4] = 128'h7b0c785e27e8ad3f8223207104725dd4;

    rst = 1'b1;
    kl_a = 1'b0; key_a = '0; iv_a = 1'b0; id_a = '0; it_a = '0;
    kl_b = 1'b0; key_b = '0; iv_b = 1'b0; id_b = '0; it_b = '0;
    da = '0; db = '0; ta = '0; tb = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst_key_ready", kr_a, 0);
    chk("rst_in_ready", ir_a, 0);
    chk("rst_out_valid", ov_a, 0);
    chk("rst_out_data", od_a, 0);
    chk("rst_out_tag", ot_a, 0);
    chk("rst_key_ready_256", kr_b, 0);

    // FIPS-197 C.1 and C.3 key expansion latency
    kl_a = 1'b1; key_a = K_C1; kl_b = 1'b1; key_b = K_C3;
    step();
    kl_a = 1'b0; kl_b = 1'b0;
    ca = -1; cb = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (kr_a && ca < 0) ca = i;
      if (kr_b && cb < 0) cb = i;
    end
    chk("c1_key_ready_lat", ca, 10);
    chk("c3_key_ready_lat", cb, 13);

    // one block on each core
    iv_a = 1'b1; id_a = PT_C; it_a = 5'd5;
    iv_b = 1'b1; id_b = PT_C; it_b = 4'd5;
    #1;
    chk("c1_in_ready", ir_a, 1);
    chk("c3_in_ready", ir_b, 1);
    step();
    iv_a = 1'b0; iv_b = 1'b0;
    la = -1; lb = -1; na = 0; nb = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (ov_a) begin na++; if (la < 0) begin la = i; da = od_a; ta = ot_a; end end
      if (ov_b) begin nb++; if (lb < 0) begin lb = i; db = od_b; tb = ot_b; end end
    end
    chk("c1_latency", la, 11);
    chk("c1_ct", da, CT_C1);
    chk("c1_tag", ta, 5);
    chk("c1_out_count", na, 1);
    chk("c3_latency", lb, 15);
    chk("c3_ct", db, CT_C3);
    chk("c3_tag", tb, 5);
    chk("c3_out_count", nb, 1);

    // reload with A.1 key; a block offered in the same cycle must be refused
    kl_a = 1'b1; key_a = K_A1; iv_a = 1'b1; id_a = pt_t[0]; it_a = 5'd9;
    #1;
    chk("load_blocks_in_ready", ir_a, 0);
    step();
    kl_a = 1'b0; iv_a = 1'b0;
    ca = -1; na = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (kr_a && ca < 0) ca = i;
      if (ov_a) na++;
    end
    chk("a1_key_ready_lat", ca, 10);
    chk("collided_block_dropped", na, 0);
    chk("a1_rk10", d128.rk[10], RK10);

    // 20 back-to-back blocks
    got = 0; first = -1; last = -1;
    for (int c = 0; c < 40; c++) begin
      if (c < 20) begin iv_a = 1'b1; id_a = pt_t[c % 5]; it_a = 5'(c); end
      else iv_a = 1'b0;
      step();
      if (ov_a) begin
        chk($sformatf("stream_ct_%0d", got), od_a, ct_t[got % 5]);
        chk($sformatf("stream_tag_%0d", got), ot_a, got);
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    chk("stream_count", got, 20);
    chk("stream_first_latency", first, 11);
    chk("stream_contiguous", last - first, 19);

    // key change with 3 blocks in flight
    for (int c = 0; c < 3; c++) begin
      iv_a = 1'b1; id_a = pt_t[c+1]; it_a = 5'(c + 1);
      step();
    end
    kl_a = 1'b1; key_a = K_C1; iv_a = 1'b1; id_a = PT_C; it_a = 5'd7;
    #1;
    chk("key_vs_valid_in_ready", ir_a, 0);
    step();
    kl_a = 1'b0;
    chk("drain_in_ready", ir_a, 0);
    chk("drain_key_ready", kr_a, 0);
    n = 0; rise = -1; seen3 = -1; viol = 0; sent = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (sent) iv_a = 1'b0;
      kl_a = 1'b0;
      if (ov_a) begin
        if (n < 4) begin od_s[n] = od_a; ot_s[n] = ot_a; end
        n++;
        if (n == 3) seen3 = c;
      end
      if (kr_a && rise < 0) rise = c;
      // garbage key while the new key is being expanded: must be ignored
      if (seen3 >= 0 && c == seen3 + 5) begin kl_a = 1'b1; key_a = '1; end
      #1;
      if (!kr_a && ir_a) viol++;
      sent = iv_a && ir_a;
    end
    chk("swap_out_count", n, 4);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("swap_old_ct_%0d", i), od_s[i], ct_t[i+1]);
      chk($sformatf("swap_old_tag_%0d", i), ot_s[i], i + 1);
    end
    chk("swap_new_ct", od_s[3], CT_C1);
    chk("swap_new_tag", ot_s[3], 7);
    chk("swap_ready_without_key", viol, 0);
    chk("swap_key_ready_rose", (rise >= 0) ? 1 : 0, 1);

    // reset with 5 blocks in flight
    for (int c = 0; c < 5; c++) begin
      iv_a = 1'b1; id_a = pt_t[c]; it_a = 5'(c);
      step();
    end
    iv_a = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_data", od_a, 0);
    chk("midrst_out_tag", ot_a, 0);
    na = 0; kc = 0; irc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (ov_a) na++;
      if (kr_a) kc++;
      if (ir_a) irc++;
    end
    chk("midrst_out_valid", na, 0);
    chk("midrst_key_ready", kc, 0);
    chk("midrst_in_ready", irc, 0);

    kl_a = 1'b1; key_a = K_A1;
    step();
    kl_a = 1'b0;
    ca = -1;
    for (int i = 1; i <= 30 && ca < 0; i++) begin
      step();
      if (kr_a) ca = i;
    end
    chk("postrst_key_ready_lat", ca, 10);
    iv_a = 1'b1; id_a = pt_t[0]; it_a = 5'd3;
    step();
    iv_a = 1'b0;
    la = -1;
    for (int i = 1; i <= 20 && la < 0; i++) begin
      step();
      if (ov_a) begin la = i; da = od_a; ta = ot_a; end
    end
    chk("postrst_latency", la, 11);
    chk("postrst_ct", da, ct_t[0]);
    chk("postrst_tag", ta, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
